// File: rtl/module_keypad_scan.sv
// rtl/module_keypad_scan.sv - 4x4 matrix keypad scanner with debounce, one-cycle press pulse and key code
// Optional KEYPAD_SYNC_EN inserts a 2-flop synchroniser on the row inputs.
module module_keypad_scan #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       press,
  output logic       busy
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] STAB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  state_t        state;
  logic [DW-1:0] dwell;
  logic [CW-1:0] stab;
  logic [1:0]    col_idx;
  logic [3:0]    row_cap;
  logic [3:0]    rs;
  logic          single_low;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] row_meta;
  logic [3:0] row_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign rs = row_sync;
`else
  assign rs = row;
`endif

  // Two or more rows low (ghosting / multi-key) never qualifies as a closure.
  assign single_low = (rs == 4'b1110) || (rs == 4'b1101) ||
                      (rs == 4'b1011) || (rs == 4'b0111);

  assign col  = ~(4'b0001 << col_idx);
  assign busy = (state != S_SCAN);

  function automatic logic [1:0] row_index(input logic [3:0] pat);
    case (pat)
      4'b1110: row_index = 2'd0;
      4'b1101: row_index = 2'd1;
      4'b1011: row_index = 2'd2;
      default: row_index = 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0:    key_lookup = 4'h1;
      4'h1:    key_lookup = 4'h2;
      4'h2:    key_lookup = 4'h3;
      4'h3:    key_lookup = 4'hA;
      4'h4:    key_lookup = 4'h4;
      4'h5:    key_lookup = 4'h5;
      4'h6:    key_lookup = 4'h6;
      4'h7:    key_lookup = 4'hB;
      4'h8:    key_lookup = 4'h7;
      4'h9:    key_lookup = 4'h8;
      4'hA:    key_lookup = 4'h9;
      4'hB:    key_lookup = 4'hC;
      4'hC:    key_lookup = 4'hE;
      4'hD:    key_lookup = 4'h0;
      4'hE:    key_lookup = 4'hF;
      default: key_lookup = 4'hD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_SCAN;
      dwell    <= '0;
      stab     <= '0;
      col_idx  <= 2'd0;
      row_cap  <= 4'hF;
      key_code <= 4'h0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        S_SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (single_low) begin
              row_cap <= rs;
              stab    <= '0;
              state   <= S_DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        S_DEBOUNCE: begin
          // A mismatch rescans the same column from a fresh dwell.
          if (rs != row_cap) begin
            state <= S_SCAN;
            dwell <= '0;
            stab  <= '0;
          end else if (stab == STAB_LAST) begin
            state <= S_PRESSED;
            stab  <= '0;
          end else begin
            stab <= stab + CW'(1);
          end
        end
        S_PRESSED: begin
          press    <= 1'b1;
          key_code <= key_lookup(row_index(row_cap), col_idx);
          stab     <= '0;
          state    <= S_RELEASE;
        end
        S_RELEASE: begin
          if (rs != 4'hF) begin
            stab <= '0;
          end else if (stab == STAB_LAST) begin
            state   <= S_SCAN;
            stab    <= '0;
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
          end else begin
            stab <= stab + CW'(1);
          end
        end
        default: state <= S_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_module_keypad_scan.sv
// tb/tb_module_keypad_scan.sv - randomized self-checking bench for module_keypad_scan against a timestamp model
`timescale 1ns/1ps
module tb_module_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int P_SCAN = 0, P_DEB = 1, P_PRS = 2, P_REL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        press;
  logic        busy;
  logic [15:0] keys = 16'h0;

  int total = 0;
  int bad = 0;
  int tcyc = 0;

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

  int         dut_cyc_q[$];
  logic [3:0] dut_code_q[$];
  int         mdl_cyc_q[$];

  always #5 clk = ~clk;

  // Physical matrix: a held key (bit r*4+c) pulls row r low while column c is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  module_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .press    (press),
    .busy     (busy)
  );

  // Reference: phases tracked by cycle timestamps (column start, detect time, quiet start).
  int         m_phase, m_cyc, m_col, m_col_start, m_det, m_quiet, m_ri;
  logic [3:0] m_pat, m_s1, m_s2, m_rs;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = P_SCAN; m_cyc = 0; m_col = 0; m_col_start = 0;
      m_det = 0; m_quiet = 0; m_pat = 4'hF; m_s1 = 4'hF; m_s2 = 4'hF;
    end else begin
`ifdef KEYPAD_SYNC_EN
      m_rs = m_s2; m_s2 = m_s1; m_s1 = row;
`else
      m_rs = row;
`endif
      case (m_phase)
        P_SCAN: if (m_cyc - m_col_start == SD - 1) begin
          if ($countones(~m_rs) == 1) begin
            m_pat = m_rs; m_det = m_cyc; m_phase = P_DEB;
          end else begin
            m_col = (m_col + 1) % 4; m_col_start = m_cyc + 1;
          end
        end
        P_DEB: if (m_rs != m_pat) begin
          m_phase = P_SCAN; m_col_start = m_cyc + 1;
        end else if (m_cyc - m_det == DB) begin
          m_phase = P_PRS;
        end
        P_PRS: begin
          mdl_cyc_q.push_back(tcyc);
          m_phase = P_REL; m_quiet = m_cyc + 1;
        end
        default: if (m_rs != 4'hF) begin
          m_quiet = m_cyc + 1;
        end else if (m_cyc - m_quiet == DB - 1) begin
          m_phase = P_SCAN; m_col = (m_col + 1) % 4; m_col_start = m_cyc + 1;
        end
      endcase
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (press === 1'b1) begin
      dut_cyc_q.push_back(tcyc);
      dut_code_q.push_back(key_code);
    end
    tcyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q();
    dut_cyc_q.delete(); dut_code_q.delete(); mdl_cyc_q.delete();
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    reset = 1'b0; keys = 16'h0;
    tick(3);
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL rst_col got=%b want=1110", col); end
    total++; if (press !== 1'b0) begin bad++; $display("FAIL rst_press got=%b want=0", press); end
    total++; if (key_code !== 4'h0) begin bad++; $display("FAIL rst_code got=%h want=0", key_code); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    reset = 1'b1;
    clear_q();
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((j / SD) % 4));
      total++; if (col !== exp_col) begin bad++; $display("FAIL idle_col j=%0d got=%b want=%b", j, col, exp_col); end
      total++; if (press !== 1'b0 || key_code !== 4'h0) begin
        bad++; $display("FAIL idle_out j=%0d got press=%b code=%h want 0/0", j, press, key_code);
      end
    end
    tick(1);
  endtask

  task automatic test_single_key();
    clear_q();
    keys = 16'h0; keys[1*4+2] = 1'b1;
    tick(40);
    keys = 16'h0;
    tick(30);
    total++; if (dut_cyc_q.size() != 1) begin bad++; $display("FAIL key6_count got=%0d want=1", dut_cyc_q.size()); end
    if (dut_cyc_q.size() > 0 && mdl_cyc_q.size() > 0) begin
      total++; if (dut_code_q[0] !== 4'h6) begin bad++; $display("FAIL key6_code got=%h want=6", dut_code_q[0]); end
      total++; if (dut_cyc_q[0] != mdl_cyc_q[0]) begin bad++; $display("FAIL key6_time got=%0d want=%0d", dut_cyc_q[0], mdl_cyc_q[0]); end
    end
    total++; if (key_code !== 4'h6) begin bad++; $display("FAIL key6_hold got=%h want=6", key_code); end
  endtask

  task automatic test_bounce();
    clear_q();
    keys = 16'h0;
    repeat (3) begin keys[14] = 1'b1; tick(1); keys[14] = 1'b0; tick(1); end
    keys[14] = 1'b1;
    tick(40);
    keys = 16'h0;
    tick(30);
    total++; if (dut_cyc_q.size() != 1) begin bad++; $display("FAIL hash_count got=%0d want=1", dut_cyc_q.size()); end
    if (dut_cyc_q.size() > 0 && mdl_cyc_q.size() > 0) begin
      total++; if (dut_code_q[0] !== 4'hF) begin bad++; $display("FAIL hash_code got=%h want=F", dut_code_q[0]); end
      total++; if (dut_cyc_q[0] != mdl_cyc_q[0]) begin bad++; $display("FAIL hash_time got=%0d want=%0d", dut_cyc_q[0], mdl_cyc_q[0]); end
    end
  endtask

  task automatic test_ghost();
    logic [3:0] exp_col;
    clear_q();
    keys = 16'h0; keys[0] = 1'b1; keys[8] = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << m_col);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ghost_busy j=%0d got=%b want=0", j, busy); end
      total++; if (col !== exp_col) begin bad++; $display("FAIL ghost_col j=%0d got=%b want=%b", j, col, exp_col); end
    end
    keys = 16'h0;
    tick(5);
    total++; if (dut_cyc_q.size() != 0) begin bad++; $display("FAIL ghost_press got=%0d want=0", dut_cyc_q.size()); end
  endtask

  task automatic test_reset_mid();
    int guard;
    keys = 16'h0; keys[1*4+1] = 1'b1;
    guard = 0;
    while (m_phase != P_DEB && guard < 100) begin tick(1); guard++; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%b want=1", busy); end
    reset = 1'b0;
    #1;
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL mid_col got=%b want=1110", col); end
    total++; if (press !== 1'b0) begin bad++; $display("FAIL mid_press got=%b want=0", press); end
    total++; if (key_code !== 4'h0) begin bad++; $display("FAIL mid_code got=%h want=0", key_code); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    tick(2);
    clear_q();
    reset = 1'b1;
    tick(40);
    keys = 16'h0;
    tick(30);
    total++; if (dut_cyc_q.size() != 1) begin bad++; $display("FAIL mid_count got=%0d want=1", dut_cyc_q.size()); end
    if (dut_cyc_q.size() > 0 && mdl_cyc_q.size() > 0) begin
      total++; if (dut_code_q[0] !== 4'h5) begin bad++; $display("FAIL mid_key5 got=%h want=5", dut_code_q[0]); end
      total++; if (dut_cyc_q[0] != mdl_cyc_q[0]) begin bad++; $display("FAIL mid_time got=%0d want=%0d", dut_cyc_q[0], mdl_cyc_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    keys = 16'h0; keys[12] = 1'b1;
    tick(40);
    keys[12] = 1'b0; tick(1); keys[12] = 1'b1; tick(1); keys[12] = 1'b0; tick(1);
    tick(30);
    keys[13] = 1'b1;
    tick(40);
    keys = 16'h0;
    tick(30);
    total++; if (dut_cyc_q.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", dut_cyc_q.size()); end
    if (dut_cyc_q.size() == 2 && mdl_cyc_q.size() == 2) begin
      total++; if (dut_code_q[0] !== 4'hE) begin bad++; $display("FAIL b2b_first got=%h want=E", dut_code_q[0]); end
      total++; if (dut_code_q[1] !== 4'h0) begin bad++; $display("FAIL b2b_second got=%h want=0", dut_code_q[1]); end
      total++; if (dut_cyc_q[1] != mdl_cyc_q[1]) begin bad++; $display("FAIL b2b_time got=%0d want=%0d", dut_cyc_q[1], mdl_cyc_q[1]); end
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_codes[$];
    int k;
    clear_q();
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 15);
      exp_codes.push_back(kmap[k]);
      keys = 16'h0;
      repeat ($urandom_range(0, 3)) begin keys[k] = 1'b1; tick(1); keys[k] = 1'b0; tick(1); end
      keys[k] = 1'b1;
      tick($urandom_range(32, 50));
      repeat ($urandom_range(0, 3)) begin keys[k] = 1'b0; tick(1); keys[k] = 1'b1; tick(1); end
      keys = 16'h0;
      tick($urandom_range(25, 40));
    end
    total++; if (dut_cyc_q.size() != 8) begin bad++; $display("FAIL rnd_count got=%0d want=8", dut_cyc_q.size()); end
    for (int i = 0; i < 8 && i < dut_cyc_q.size(); i++) begin
      total++; if (dut_code_q[i] !== exp_codes[i]) begin bad++; $display("FAIL rnd_code i=%0d got=%h want=%h", i, dut_code_q[i], exp_codes[i]); end
      if (i < mdl_cyc_q.size()) begin
        total++; if (dut_cyc_q[i] != mdl_cyc_q[i]) begin bad++; $display("FAIL rnd_time i=%0d got=%0d want=%0d", i, dut_cyc_q[i], mdl_cyc_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_ghost();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
